// File: rtl/tcm_ram_2rw_if.sv
// One port of the dual-port TCM: request/grant handshake plus the delayed response.
// The master drives the request side; the memory is the slave.
interface tcm_ram_2rw_if #(
   parameter int DATA_WIDTH = 32
);
   logic [31:0]             address;
   logic                    request;
   logic                    write_enable;
   logic [DATA_WIDTH/8-1:0] write_byte_enable;
   logic [DATA_WIDTH-1:0]   write_data;
   logic                    grant;
   logic [DATA_WIDTH-1:0]   read_data;
   logic                    valid;
   logic                    error;

   modport master (
      output address, request, write_enable, write_byte_enable, write_data,
      input  grant, read_data, valid, error
   );

   modport slave (
      input  address, request, write_enable, write_byte_enable, write_data,
      output grant, read_data, valid, error
   );
endinterface

// File: rtl/tcm_ram_2rw.sv
// True dual-port tightly-coupled memory with byte enables, read-first cross-port behaviour,
// 1- or 2-cycle response latency and an error response for accesses outside the window.
module tcm_ram_2rw #(
   parameter logic [31:0] START_ADDRESS = 32'h0,
   parameter int          SIZE          = 4096,
   parameter int          DATA_WIDTH    = 32,
   parameter int          READ_LATENCY  = 1
) (
   input  logic          aclk,
   input  logic          aresetn,
   tcm_ram_2rw_if.slave  port_a,
   tcm_ram_2rw_if.slave  port_b
);
   localparam int BW    = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BW);
   localparam int AW    = $clog2(SIZE);
   localparam int DEPTH = SIZE / BW;
   localparam int IW    = AW - OFF;
   localparam logic [32:0] START_EXT = {1'b0, START_ADDRESS};
   localparam logic [32:0] END_EXT   = {1'b0, START_ADDRESS} + 33'(SIZE);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Index 0 is port A, index 1 is port B.
   logic [1:0][31:0]           addr;
   logic [1:0]                 req, we;
   logic [1:0][BW-1:0]         be;
   logic [1:0][DATA_WIDTH-1:0] wdata;

   assign addr[0]  = port_a.address;
   assign addr[1]  = port_b.address;
   assign req[0]   = port_a.request;
   assign req[1]   = port_b.request;
   assign we[0]    = port_a.write_enable;
   assign we[1]    = port_b.write_enable;
   assign be[0]    = port_a.write_byte_enable;
   assign be[1]    = port_b.write_byte_enable;
   assign wdata[0] = port_a.write_data;
   assign wdata[1] = port_b.write_data;

   logic [1:0]         in_range, grant, wr, rd;
   logic [1:0][IW-1:0] idx;
   logic               collide;

   assign in_range[0] = ({1'b0, addr[0]} >= START_EXT) && ({1'b0, addr[0]} < END_EXT);
   assign in_range[1] = ({1'b0, addr[1]} >= START_EXT) && ({1'b0, addr[1]} < END_EXT);
   assign idx[0]      = addr[0][AW-1:OFF];
   assign idx[1]      = addr[1][AW-1:OFF];

   // Two writes to one word would race in the array, so A wins and B is held off a cycle.
   assign collide = req[0] & we[0] & in_range[0] &
                    req[1] & we[1] & in_range[1] & (idx[0] == idx[1]);

   assign grant[0] = req[0];
   assign grant[1] = req[1] & ~collide;
   assign wr       = grant & we & in_range;
   assign rd       = grant & ~we & in_range;

   assign port_a.grant = grant[0];
   assign port_b.grant = grant[1];

   always_ff @(posedge aclk) begin
      for (int p = 0; p < 2; p++) begin
         for (int b = 0; b < BW; b++) begin
            if (wr[p] && be[p][b]) mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
         end
      end
   end

   // Stage 1: array output register. Reads see pre-edge contents, giving read-first.
   logic [1:0]                 s1_vld_d, s1_vld_q, s1_err_d, s1_err_q;
   logic [1:0][DATA_WIDTH-1:0] s1_data_d, s1_data_q;

   always_comb begin
      s1_vld_d  = grant;
      s1_err_d  = grant & ~in_range;
      s1_data_d = s1_data_q;
      for (int p = 0; p < 2; p++) begin
         if (rd[p]) s1_data_d[p] = mem[idx[p]];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s1_vld_q  <= '0;
         s1_err_q  <= '0;
         s1_data_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_err_q  <= s1_err_d;
         s1_data_q <= s1_data_d;
      end
   end

   logic [1:0]                 out_vld, out_err;
   logic [1:0][DATA_WIDTH-1:0] out_data;

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [1:0]                 s1_rd_q, out_vld_q, out_err_q;
         logic [1:0]                 out_vld_d, out_err_d;
         logic [1:0][DATA_WIDTH-1:0] out_data_d, out_data_q;

         always_comb begin
            out_vld_d  = s1_vld_q;
            out_err_d  = s1_err_q;
            out_data_d = out_data_q;
            for (int p = 0; p < 2; p++) begin
               if (s1_vld_q[p] && s1_rd_q[p]) out_data_d[p] = s1_data_q[p];
            end
         end

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               s1_rd_q    <= '0;
               out_vld_q  <= '0;
               out_err_q  <= '0;
               out_data_q <= '0;
            end else begin
               s1_rd_q    <= rd;
               out_vld_q  <= out_vld_d;
               out_err_q  <= out_err_d;
               out_data_q <= out_data_d;
            end
         end

         assign out_vld  = out_vld_q;
         assign out_err  = out_err_q;
         assign out_data = out_data_q;
      end else begin : g_lat1
         assign out_vld  = s1_vld_q;
         assign out_err  = s1_err_q;
         assign out_data = s1_data_q;
      end
   endgenerate

   assign port_a.valid     = out_vld[0];
   assign port_b.valid     = out_vld[1];
   assign port_a.error     = out_err[0];
   assign port_b.error     = out_err[1];
   assign port_a.read_data = out_data[0];
   assign port_b.read_data = out_data[1];
endmodule
